// File: rtl/uart_frame_loader.sv
// Drains the UART receive FIFO into the input frame RAM and flags frame completion or timeout.
// Optional trailer checksum verification is enabled by defining UART_FRAME_LOADER_CHECKSUM_EN.
module uart_frame_loader #(
  parameter int unsigned MAX_ROW        = 76800,
  parameter int unsigned A              = 17,
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         start_i,
  input  logic         rx_empty_i,
  input  logic [7:0]   rx_rdata_i,
  output logic         rx_rd_en_o,
  output logic         rx_active_o,
  output logic         ram_en_o,
  output logic         ram_we_o,
  output logic [A-1:0] ram_addr_o,
  output logic [7:0]   ram_data_o,
  output logic         busy_o,
  output logic [A:0]   byte_cnt_o,
  output logic         frame_done_o,
  output logic         timeout_o,
  output logic         checksum_err_o
);

  localparam int unsigned CW = A + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(MAX_ROW);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BYTE = 3'd1,
    WRITE     = 3'd2,
    CHECK     = 3'd3,
    DONE      = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic            rx_rd_en_q, rx_rd_en_d;
  logic            rx_active_q, rx_active_d;
  logic            ram_en_q, ram_en_d;
  logic            ram_we_q, ram_we_d;
  logic [A-1:0]    ram_addr_q, ram_addr_d;
  logic [7:0]      ram_data_q, ram_data_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
  logic            frame_done_q, frame_done_d;
  logic            timeout_q, timeout_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [TW-1:0]   tmo_inc;
  logic            tmo_hit;
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
  logic [7:0]      sum_q, sum_d;
  logic            checksum_err_q, checksum_err_d;
`endif

  assign tmo_inc = tmo_cnt_q + TW'(1);
  assign tmo_hit = (tmo_inc == TMO_LIMIT);

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    rx_rd_en_d   = 1'b0;
    ram_en_d     = 1'b0;
    ram_we_d     = 1'b0;
    frame_done_d = 1'b0;
    rx_active_d  = rx_active_q;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    byte_cnt_d   = byte_cnt_q;
    timeout_d    = timeout_q;
    tmo_cnt_d    = tmo_cnt_q;
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
    sum_d          = sum_q;
    checksum_err_d = checksum_err_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_i) begin
          byte_cnt_d  = '0;
          timeout_d   = 1'b0;
          tmo_cnt_d   = '0;
          rx_active_d = 1'b1;
          state_d     = WAIT_BYTE;
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
          sum_d          = '0;
          checksum_err_d = 1'b0;
`endif
        end
      end

      WAIT_BYTE: begin
        // A byte present in the same cycle as the timeout takes priority
        if (!rx_empty_i) begin
          rx_rd_en_d = 1'b1;
          ram_en_d   = 1'b1;
          ram_we_d   = 1'b1;
          ram_addr_d = byte_cnt_q[A-1:0];
          ram_data_d = rx_rdata_i;
          byte_cnt_d = byte_cnt_q + CW'(1);
          tmo_cnt_d  = '0;
          state_d    = WRITE;
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
          sum_d = sum_q + rx_rdata_i;
`endif
        end else if (byte_cnt_q != '0) begin
          tmo_cnt_d = tmo_inc;
          if (tmo_hit) begin
            timeout_d   = 1'b1;
            rx_active_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end

      WRITE: begin
        state_d = (byte_cnt_q == FULL_CNT) ? CHECK : WAIT_BYTE;
      end

      CHECK: begin
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
        // Trailer byte is popped but never written to RAM
        if (!rx_empty_i) begin
          rx_rd_en_d = 1'b1;
          tmo_cnt_d  = '0;
          if (rx_rdata_i != sum_q) checksum_err_d = 1'b1;
          state_d = DONE;
        end else begin
          tmo_cnt_d = tmo_inc;
          if (tmo_hit) begin
            timeout_d   = 1'b1;
            rx_active_d = 1'b0;
            state_d     = IDLE;
          end
        end
`else
        frame_done_d = 1'b1;
        rx_active_d  = 1'b0;
        state_d      = DONE;
`endif
      end

      DONE: begin
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
        // Done pulse follows the trailer pop by one cycle
        frame_done_d = 1'b1;
        rx_active_d  = 1'b0;
`endif
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      rx_rd_en_q   <= 1'b0;
      rx_active_q  <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      busy_q       <= 1'b0;
      byte_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      rx_rd_en_q   <= rx_rd_en_d;
      rx_active_q  <= rx_active_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      busy_q       <= busy_d;
      byte_cnt_q   <= byte_cnt_d;
      frame_done_q <= frame_done_d;
      timeout_q    <= timeout_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

`ifdef UART_FRAME_LOADER_CHECKSUM_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sum_q          <= '0;
      checksum_err_q <= 1'b0;
    end else begin
      sum_q          <= sum_d;
      checksum_err_q <= checksum_err_d;
    end
  end

  assign checksum_err_o = checksum_err_q;
`else
  assign checksum_err_o = 1'b0;
`endif

  assign rx_rd_en_o   = rx_rd_en_q;
  assign rx_active_o  = rx_active_q;
  assign ram_en_o     = ram_en_q;
  assign ram_we_o     = ram_we_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_data_o   = ram_data_q;
  assign busy_o       = busy_q;
  assign byte_cnt_o   = byte_cnt_q;
  assign frame_done_o = frame_done_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Self-checking bench for uart_frame_loader: FIFO model, RAM write log and per-scenario checks.
// Covers both builds; checksum scenarios depend on UART_FRAME_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_uart_frame_loader;

  localparam int unsigned MAX_ROW = 4;
  localparam int unsigned A       = 2;
  localparam int unsigned TMO     = 16;
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
  localparam int unsigned DONE_LAT = 3;
  localparam int unsigned POPS_PER_FRAME = MAX_ROW + 1;
`else
  localparam int unsigned DONE_LAT = 2;
  localparam int unsigned POPS_PER_FRAME = MAX_ROW;
`endif

  logic         clk_i = 1'b0;
  logic         rstn_i;
  logic         start_i;
  logic         rx_empty_i;
  logic [7:0]   rx_rdata_i;
  logic         rx_rd_en_o;
  logic         rx_active_o;
  logic         ram_en_o;
  logic         ram_we_o;
  logic [A-1:0] ram_addr_o;
  logic [7:0]   ram_data_o;
  logic         busy_o;
  logic [A:0]   byte_cnt_o;
  logic         frame_done_o;
  logic         timeout_o;
  logic         checksum_err_o;
  logic [20:0]  outs;

  uart_frame_loader #(.MAX_ROW(MAX_ROW), .A(A), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i),
    .rx_empty_i(rx_empty_i), .rx_rdata_i(rx_rdata_i), .rx_rd_en_o(rx_rd_en_o),
    .rx_active_o(rx_active_o), .ram_en_o(ram_en_o), .ram_we_o(ram_we_o),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .busy_o(busy_o),
    .byte_cnt_o(byte_cnt_o), .frame_done_o(frame_done_o), .timeout_o(timeout_o),
    .checksum_err_o(checksum_err_o)
  );

  assign outs = {rx_rd_en_o, rx_active_o, ram_en_o, ram_we_o, ram_addr_o, ram_data_o,
                 busy_o, byte_cnt_o, frame_done_o, timeout_o, checksum_err_o};

  always #5 clk_i = ~clk_i;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;
  int unsigned pops = 0;
  int unsigned dones = 0;
  int unsigned last_wr_cyc = 0;
  int unsigned done_cyc = 0;
  logic [7:0]  fifo_q[$];
  int          wr_addr_q[$];
  logic [7:0]  wr_data_q[$];

  task automatic fifo_refresh();
    rx_empty_i = (fifo_q.size() == 0);
    rx_rdata_i = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  endtask

  always @(posedge clk_i) cyc = cyc + 1;

  // FIFO pops and RAM writes observed mid-cycle; a pop strobe takes effect at the next edge
  always @(negedge clk_i) begin
    if (rstn_i === 1'b1) begin
      if (ram_en_o && ram_we_o) begin
        wr_addr_q.push_back(int'(ram_addr_o));
        wr_data_q.push_back(ram_data_o);
        last_wr_cyc = cyc;
      end
      if (rx_rd_en_o) begin
        pops++;
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        fifo_refresh();
      end
      if (frame_done_o) begin
        dones++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_refresh();
  endtask

  function automatic logic [7:0] sum8(input logic [7:0] b[$]);
    logic [7:0] s = 8'h00;
    foreach (b[i]) s = s + b[i];
    return s;
  endfunction

  task automatic push_frame(input logic [7:0] b[$]);
    foreach (b[i]) push_byte(b[i]);
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
    push_byte(sum8(b));
`endif
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    pops = 0;
    dones = 0;
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    start_i = 1'b0;
    fifo_q.delete();
    fifo_refresh();
    repeat (2) tick();
    clear_log();
    rstn_i = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int unsigned n, input int unsigned budget);
    int unsigned t = 0;
    while (dones < n && t < budget) begin
      tick();
      t++;
    end
  endtask

  task automatic wait_writes(input int n, input int unsigned budget);
    int unsigned t = 0;
    while (wr_addr_q.size() < n && t < budget) begin
      tick();
      t++;
    end
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    start_i = 1'b0;
    fifo_q.delete();
    fifo_refresh();
    repeat (2) tick();
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    rstn_i = 1'b1;
    clear_log();
    repeat (3) tick();
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL idle_after_reset: got %h expected 0", outs); end
    push_byte(8'h5A);
    repeat (6) tick();
    checks++;
    if (pops != 0 || busy_o !== 1'b0 || wr_addr_q.size() != 0)
      begin errors++; $display("FAIL idle_ignores_fifo: pops %0d busy %b writes %0d, expected 0 0 0", pops, busy_o, wr_addr_q.size()); end
  endtask

  task automatic test_basic();
    logic [7:0] exp[$];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    push_frame(exp);
    pulse_start();
    wait_done(1, 100);
    checks++;
    if (dones != 1) begin errors++; $display("FAIL basic_done: got %0d pulses expected 1", dones); end
    checks++;
    if (done_cyc - last_wr_cyc != DONE_LAT)
      begin errors++; $display("FAIL basic_done_latency: got %0d expected %0d", done_cyc - last_wr_cyc, DONE_LAT); end
    repeat (4) tick();
    checks++;
    if (wr_addr_q.size() != exp.size()) begin errors++; $display("FAIL basic_write_count: got %0d expected %0d", wr_addr_q.size(), exp.size()); end
    for (int i = 0; i < wr_addr_q.size() && i < exp.size(); i++) begin
      checks++;
      if (wr_addr_q[i] != i || wr_data_q[i] !== exp[i])
        begin errors++; $display("FAIL basic_write[%0d]: got addr %0d data %h, expected addr %0d data %h", i, wr_addr_q[i], wr_data_q[i], i, exp[i]); end
    end
    checks++;
    if (pops != POPS_PER_FRAME || dones != 1) begin errors++; $display("FAIL basic_pops_dones: got %0d/%0d expected %0d/1", pops, dones, POPS_PER_FRAME); end
    checks++;
    if (byte_cnt_o !== 3'd4 || rx_active_o !== 1'b0 || busy_o !== 1'b0 || timeout_o !== 1'b0)
      begin errors++; $display("FAIL basic_final: cnt %0d active %b busy %b tmo %b, expected 4 0 0 0", byte_cnt_o, rx_active_o, busy_o, timeout_o); end
  endtask

  task automatic test_slow_bytes();
    logic [7:0] exp[$];
    do_reset();
    repeat (MAX_ROW) exp.push_back(8'($urandom));
    pulse_start();
    repeat (40) tick();
    checks++;
    if (busy_o !== 1'b1 || rx_active_o !== 1'b1 || timeout_o !== 1'b0)
      begin errors++; $display("FAIL slow_first_wait: busy %b active %b tmo %b, expected 1 1 0", busy_o, rx_active_o, timeout_o); end
    for (int i = 0; i < MAX_ROW; i++) begin
      push_byte(exp[i]);
      repeat ($urandom_range(2, 14)) tick();
    end
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
    push_byte(sum8(exp));
`endif
    wait_done(1, 100);
    checks++;
    if (dones != 1 || timeout_o !== 1'b0) begin errors++; $display("FAIL slow_done: dones %0d tmo %b, expected 1 0", dones, timeout_o); end
    checks++;
    if (wr_addr_q.size() != exp.size()) begin errors++; $display("FAIL slow_write_count: got %0d expected %0d", wr_addr_q.size(), exp.size()); end
    for (int i = 0; i < wr_addr_q.size() && i < exp.size(); i++) begin
      checks++;
      if (wr_addr_q[i] != i || wr_data_q[i] !== exp[i])
        begin errors++; $display("FAIL slow_write[%0d]: got addr %0d data %h, expected addr %0d data %h", i, wr_addr_q[i], wr_data_q[i], i, exp[i]); end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] exp[$];
    do_reset();
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    pulse_start();
    wait_writes(2, 50);
    checks++;
    if (wr_addr_q.size() != 2) begin errors++; $display("FAIL tmo_two_writes: got %0d expected 2", wr_addr_q.size()); end
    // Sixteen idle cycles follow the write cycle; the flag appears on the next one
    repeat (TMO) tick();
    checks++;
    if (timeout_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL tmo_early: tmo %b busy %b, expected 0 1", timeout_o, busy_o); end
    tick();
    checks++;
    if ({timeout_o, busy_o, rx_active_o} !== 3'b100 || byte_cnt_o !== 3'd2)
      begin errors++; $display("FAIL tmo_flag: tmo/busy/active %b cnt %0d, expected 100 2", {timeout_o, busy_o, rx_active_o}, byte_cnt_o); end
    repeat (10) tick();
    checks++;
    if (dones != 0 || timeout_o !== 1'b1) begin errors++; $display("FAIL tmo_sticky: dones %0d tmo %b, expected 0 1", dones, timeout_o); end
    clear_log();
    repeat (MAX_ROW) exp.push_back(8'($urandom));
    push_frame(exp);
    pulse_start();
    checks++;
    if (timeout_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL tmo_restart_clear: tmo %b busy %b, expected 0 1", timeout_o, busy_o); end
    wait_done(1, 100);
    checks++;
    if (wr_addr_q.size() != exp.size() || dones != 1) begin errors++; $display("FAIL tmo_restart_count: writes %0d dones %0d, expected %0d 1", wr_addr_q.size(), dones, exp.size()); end
    for (int i = 0; i < wr_addr_q.size() && i < exp.size(); i++) begin
      checks++;
      if (wr_addr_q[i] != i || wr_data_q[i] !== exp[i])
        begin errors++; $display("FAIL tmo_restart_write[%0d]: got addr %0d data %h, expected addr %0d data %h", i, wr_addr_q[i], wr_data_q[i], i, exp[i]); end
    end
  endtask

  task automatic test_byte_wins();
    logic [7:0] exp[$];
    do_reset();
    repeat (MAX_ROW) exp.push_back(8'($urandom));
    push_byte(exp[0]);
    push_byte(exp[1]);
    pulse_start();
    wait_writes(2, 50);
    // Third byte becomes visible in the very cycle the counter would expire
    repeat (TMO) tick();
    push_byte(exp[2]);
    push_byte(exp[3]);
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
    push_byte(sum8(exp));
`endif
    wait_done(1, 100);
    checks++;
    if (dones != 1 || timeout_o !== 1'b0) begin errors++; $display("FAIL wins_done: dones %0d tmo %b, expected 1 0", dones, timeout_o); end
    checks++;
    if (wr_addr_q.size() != exp.size()) begin errors++; $display("FAIL wins_write_count: got %0d expected %0d", wr_addr_q.size(), exp.size()); end
    for (int i = 0; i < wr_addr_q.size() && i < exp.size(); i++) begin
      checks++;
      if (wr_addr_q[i] != i || wr_data_q[i] !== exp[i])
        begin errors++; $display("FAIL wins_write[%0d]: got addr %0d data %h, expected addr %0d data %h", i, wr_addr_q[i], wr_data_q[i], i, exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp[$];
    do_reset();
    repeat (3) push_byte(8'($urandom));
    pulse_start();
    wait_writes(3, 50);
    rstn_i = 1'b0;
    #1;
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL midreset_outputs: got %h expected 0", outs); end
    fifo_q.delete();
    fifo_refresh();
    tick();
    clear_log();
    rstn_i = 1'b1;
    tick();
    exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    push_frame(exp);
    pulse_start();
    wait_done(1, 100);
    checks++;
    if (wr_addr_q.size() != exp.size() || dones != 1) begin errors++; $display("FAIL midreset_count: writes %0d dones %0d, expected %0d 1", wr_addr_q.size(), dones, exp.size()); end
    for (int i = 0; i < wr_addr_q.size() && i < exp.size(); i++) begin
      checks++;
      if (wr_addr_q[i] != i || wr_data_q[i] !== exp[i])
        begin errors++; $display("FAIL midreset_write[%0d]: got addr %0d data %h, expected addr %0d data %h", i, wr_addr_q[i], wr_data_q[i], i, exp[i]); end
    end
  endtask

  task automatic test_start_toggle();
    logic [7:0] exp[$];
    int unsigned t = 0;
    do_reset();
    repeat (MAX_ROW) exp.push_back(8'($urandom));
    start_i = 1'b1;
    tick();
    for (int i = 0; i < MAX_ROW; i++) begin
      repeat ($urandom_range(1, 6)) begin
        start_i = 1'($urandom_range(0, 1));
        tick();
      end
      push_byte(exp[i]);
    end
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
    push_byte(sum8(exp));
`endif
    while (wr_addr_q.size() < MAX_ROW && t < 50) begin
      start_i = 1'($urandom_range(0, 1));
      tick();
      t++;
    end
    start_i = 1'b0;
    wait_done(1, 100);
    repeat (4) tick();
    checks++;
    if (dones != 1 || busy_o !== 1'b0) begin errors++; $display("FAIL toggle_done: dones %0d busy %b, expected 1 0", dones, busy_o); end
    checks++;
    if (wr_addr_q.size() != exp.size()) begin errors++; $display("FAIL toggle_write_count: got %0d expected %0d", wr_addr_q.size(), exp.size()); end
    for (int i = 0; i < wr_addr_q.size() && i < exp.size(); i++) begin
      checks++;
      if (wr_addr_q[i] != i || wr_data_q[i] !== exp[i])
        begin errors++; $display("FAIL toggle_write[%0d]: got addr %0d data %h, expected addr %0d data %h", i, wr_addr_q[i], wr_data_q[i], i, exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] f0[$];
    logic [7:0] f1[$];
    logic [7:0] exp[$];
    do_reset();
    repeat (MAX_ROW) f0.push_back(8'($urandom));
    repeat (MAX_ROW) f1.push_back(8'($urandom));
    push_frame(f0);
    push_frame(f1);
    exp = {f0, f1};
    start_i = 1'b1;
    wait_done(2, 200);
    start_i = 1'b0;
    repeat (4) tick();
    checks++;
    if (dones != 2 || pops != 2 * POPS_PER_FRAME)
      begin errors++; $display("FAIL b2b_counts: dones %0d pops %0d, expected 2 %0d", dones, pops, 2 * POPS_PER_FRAME); end
    checks++;
    if (busy_o !== 1'b0 || byte_cnt_o !== 3'd4) begin errors++; $display("FAIL b2b_final: busy %b cnt %0d, expected 0 4", busy_o, byte_cnt_o); end
    checks++;
    if (wr_addr_q.size() != exp.size()) begin errors++; $display("FAIL b2b_write_count: got %0d expected %0d", wr_addr_q.size(), exp.size()); end
    for (int i = 0; i < wr_addr_q.size() && i < exp.size(); i++) begin
      checks++;
      if (wr_addr_q[i] != i % MAX_ROW || wr_data_q[i] !== exp[i])
        begin errors++; $display("FAIL b2b_write[%0d]: got addr %0d data %h, expected addr %0d data %h", i, wr_addr_q[i], wr_data_q[i], i % MAX_ROW, exp[i]); end
    end
  endtask

`ifdef UART_FRAME_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] exp[$];
    logic [7:0] trailer;
    for (int k = 0; k < 4; k++) begin
      do_reset();
      exp.delete();
      if (k < 2) exp = '{8'h01, 8'h02, 8'h03, 8'h04};
      else repeat (MAX_ROW) exp.push_back(8'($urandom));
      if (k == 0) trailer = 8'h0A;
      else if (k == 1) trailer = 8'h0B;
      else if (k == 2) trailer = sum8(exp);
      else trailer = sum8(exp) + 8'($urandom_range(1, 255));
      foreach (exp[i]) push_byte(exp[i]);
      push_byte(trailer);
      pulse_start();
      wait_done(1, 100);
      repeat (3) tick();
      checks++;
      if (checksum_err_o !== 1'(k % 2))
        begin errors++; $display("FAIL csum_err[%0d]: got %b expected %b", k, checksum_err_o, 1'(k % 2)); end
      checks++;
      if (dones != 1 || pops != MAX_ROW + 1 || wr_addr_q.size() != MAX_ROW || fifo_q.size() != 0)
        begin errors++; $display("FAIL csum_counts[%0d]: dones %0d pops %0d writes %0d left %0d, expected 1 %0d %0d 0", k, dones, pops, wr_addr_q.size(), fifo_q.size(), MAX_ROW + 1, MAX_ROW); end
    end
  endtask
`else
  task automatic test_no_checksum();
    logic [7:0] exp[$];
    do_reset();
    repeat (MAX_ROW) exp.push_back(8'($urandom));
    foreach (exp[i]) push_byte(exp[i]);
    push_byte(8'hEE);
    pulse_start();
    wait_done(1, 100);
    repeat (5) tick();
    checks++;
    if (pops != MAX_ROW || fifo_q.size() != 1 || checksum_err_o !== 1'b0 || wr_addr_q.size() != MAX_ROW)
      begin errors++; $display("FAIL nocsum_trailer: pops %0d left %0d err %b writes %0d, expected %0d 1 0 %0d", pops, fifo_q.size(), checksum_err_o, wr_addr_q.size(), MAX_ROW, MAX_ROW); end
  endtask
`endif

  initial begin
    rstn_i = 1'b0;
    start_i = 1'b0;
    rx_empty_i = 1'b1;
    rx_rdata_i = 8'h00;
    test_reset();
    test_basic();
    test_slow_bytes();
    test_timeout();
    test_byte_wins();
    test_reset_mid();
    test_start_toggle();
    test_back_to_back();
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
    test_checksum();
`else
    test_no_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
